// File: rtl/clk_div_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_sched_pkg
//  Description : Shared types and constants for the divided-clock scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_sched_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_SEL_W = 3;
    localparam int CNT_W     = 2 ** DEF_SEL_W;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } ch_state_e;

    // A channel produces a waveform in every state except OFF.
    function automatic logic is_live(input ch_state_e st);
        return (st != OFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_sched_ch.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_sched_ch
//  Description : One divide channel: state machine, period counter and
//                registered phase/tick/pend outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_sched_ch
    import clk_div_sched_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_acc,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_on,
    output logic             o_phase,
    output logic             o_tick,
    output logic             o_pend
);

    localparam int C_CNT_W = 2 ** SEL_W;

    ch_state_e          r_state;
    ch_state_e          w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic [C_CNT_W-1:0] w_cnt_run;
    logic [C_CNT_W-1:0] w_mask;
    logic [C_CNT_W-1:0] w_mask_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   r_stg_sel;
    logic [SEL_W-1:0]   w_stg_sel_nxt;
    logic               r_stg_on;
    logic               w_stg_on_nxt;
    logic               w_tick_now;
    logic               r_phase;
    logic               r_tick;
    logic               w_phase_nxt;
    logic               w_tick_nxt;

    // Low (sel+1) bits set: the counter bits that make up one period.
    function automatic logic [C_CNT_W-1:0] period_mask(input logic [SEL_W-1:0] sel);
        logic [C_CNT_W-1:0] m;
        for (int i = 0; i < C_CNT_W; i++) begin
            m[i] = (i <= int'(sel));
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= OFF;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_stg_sel <= '0;
            r_stg_on  <= 1'b0;
            r_phase   <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sel     <= w_sel_nxt;
            r_stg_sel <= w_stg_sel_nxt;
            r_stg_on  <= w_stg_on_nxt;
            r_phase   <= w_phase_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_stg_sel_nxt = r_stg_sel;
        w_stg_on_nxt  = r_stg_on;
        w_mask        = period_mask(r_sel);
        w_tick_now    = is_live(r_state) && ((r_cnt & w_mask) == w_mask);
        w_cnt_run     = w_tick_now ? '0 : (r_cnt + C_CNT_W'(1));
        w_cnt_nxt     = w_cnt_run;

        case (r_state)
            OFF: begin
                w_cnt_nxt = '0;
                if (i_acc && i_on) begin
                    w_sel_nxt   = i_sel;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // A write landing on the tick cycle waits for the next tick.
                if (i_acc) begin
                    w_stg_sel_nxt = i_sel;
                    w_stg_on_nxt  = i_on;
                    w_state_nxt   = PEND;
                end
            end
            PEND: begin
                if (w_tick_now) begin
                    w_cnt_nxt = '0;
                    if (r_stg_on) begin
                        w_sel_nxt   = r_stg_sel;
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = OFF;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = OFF;
            end
        endcase

        // Outputs are registered from the next-cycle counter view.
        w_mask_nxt  = period_mask(w_sel_nxt);
        w_phase_nxt = is_live(w_state_nxt) && w_cnt_nxt[w_sel_nxt];
        w_tick_nxt  = is_live(w_state_nxt) && ((w_cnt_nxt & w_mask_nxt) == w_mask_nxt);
    end

    assign o_phase = r_phase;
    assign o_tick  = r_tick;
    assign o_pend  = (r_state == PEND);

endmodule
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_sched
//  Description : NCH-channel programmable clock-divide scheduler with a
//                valid/ready config port. Optional macro
//                CLK_DIV_SCHED_AND_EN adds strobe output y = phase[0]&phase[1].
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_sched
    import clk_div_sched_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int SEL_W = DEF_SEL_W,
    parameter int CH_W  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic             cfg_on,
    output logic [NCH-1:0]   phase,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pend
`ifdef CLK_DIV_SCHED_AND_EN
    ,
    output logic             y
`endif
);

    logic [NCH-1:0] w_acc;

    // A channel holding a staged config refuses further writes.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if ((cfg_ch == CH_W'(i)) && pend[i]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_acc[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        clk_div_sched_ch #(
            .SEL_W (SEL_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_acc   (w_acc[g]),
            .i_sel   (cfg_sel),
            .i_on    (cfg_on),
            .o_phase (phase[g]),
            .o_tick  (tick[g]),
            .o_pend  (pend[g])
        );
    end

`ifdef CLK_DIV_SCHED_AND_EN
    logic r_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y <= 1'b0;
        end else begin
            r_y <= phase[0] & phase[1];
        end
    end

    assign y = r_y;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_sched
//  Description : Directed self-checking bench for clk_div_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_sched;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [2:0] cfg_sel;
    logic       cfg_on;
    logic [3:0] phase;
    logic [3:0] tick;
    logic [3:0] pend;
`ifdef CLK_DIV_SCHED_AND_EN
    logic       y;
`endif

    int n_cmp;
    int n_err;

    clk_div_sched dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_on    (cfg_on),
        .phase     (phase),
        .tick      (tick),
        .pend      (pend)
`ifdef CLK_DIV_SCHED_AND_EN
        ,
        .y         (y)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds valid for exactly one edge; returns 1 time unit after that edge.
    task automatic cfg_write(input logic [1:0] ch, input logic [2:0] sel, input logic on);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_sel   = sel;
        cfg_on    = on;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_sel   = 3'd0;
        cfg_on    = 1'b0;
        step();
        step();

        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);

        reset = 1'b0;
        step();
        chk("idle_phase", 32'(phase), 32'h0);

        // ch0 divide-by-2: phase/tick toggle each cycle, first tick 2 cycles after accept
        cfg_write(2'd0, 3'd0, 1'b1);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("ch0_phase_j%0d", j), 32'(phase[0]), 32'(j % 2));
            chk($sformatf("ch0_tick_j%0d", j), 32'(tick[0]), 32'(j % 2));
            chk($sformatf("ch0_ready_j%0d", j), 32'(cfg_ready), 32'h1);
            step();
        end

        // ch1 divide-by-8: low 4, high 4, tick on last high cycle
        cfg_write(2'd1, 3'd2, 1'b1);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("ch1_phase_j%0d", j), 32'(phase[1]), 32'((j % 8) >= 4));
            chk($sformatf("ch1_tick_j%0d", j), 32'(tick[1]), 32'((j % 8) == 7));
            step();
        end
        step();
        step();

        // Retarget ch1 to divide-by-2 mid-period (count 2 -> 3)
        cfg_write(2'd1, 3'd0, 1'b1);
        cfg_ch = 2'd1;
        #1;
        for (int k = 3; k < 8; k++) begin
            chk($sformatf("ch1_pend_k%0d", k), 32'(pend[1]), 32'h1);
            chk($sformatf("ch1_ready_k%0d", k), 32'(cfg_ready), 32'h0);
            chk($sformatf("ch1_oldphase_k%0d", k), 32'(phase[1]), 32'(k >= 4));
            chk($sformatf("ch1_oldtick_k%0d", k), 32'(tick[1]), 32'(k == 7));
            step();
        end
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("ch1_newphase_j%0d", j), 32'(phase[1]), 32'(j % 2));
            chk($sformatf("ch1_newtick_j%0d", j), 32'(tick[1]), 32'(j % 2));
            chk($sformatf("ch1_newpend_j%0d", j), 32'(pend[1]), 32'h0);
            step();
        end

        // ch2 divide-by-4, retarget at once; then a second write is stalled
        cfg_write(2'd2, 3'd1, 1'b1);
        cfg_write(2'd2, 3'd0, 1'b1);
        chk("ch2_pend_set", 32'(pend[2]), 32'h1);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_sel   = 3'd2;
        cfg_on    = 1'b1;
        #1;
        chk("ch2_stall_ready0", 32'(cfg_ready), 32'h0);
        step();
        chk("ch2_stall_ready1", 32'(cfg_ready), 32'h0);
        chk("ch2_stall_pend", 32'(pend[2]), 32'h1);
        cfg_ch  = 2'd3;
        cfg_sel = 3'd1;
        #1;
        chk("ch3_ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        chk("ch3_started_pend", 32'(pend[3]), 32'h0);
        chk("ch3_j0_phase", 32'(phase[3]), 32'h0);
        chk("ch2_oldtick", 32'(tick[2]), 32'h1);
        chk("ch2_oldphase", 32'(phase[2]), 32'h1);
        chk("ch2_pend_tick", 32'(pend[2]), 32'h1);
        step();
        chk("ch2_new_pend", 32'(pend[2]), 32'h0);
        chk("ch2_new_phase0", 32'(phase[2]), 32'h0);
        chk("ch3_j1_phase", 32'(phase[3]), 32'h0);
        step();
        chk("ch2_new_phase1", 32'(phase[2]), 32'h1);
        chk("ch2_new_tick1", 32'(tick[2]), 32'h1);
        chk("ch3_j2_phase", 32'(phase[3]), 32'h1);
        chk("ch3_j2_tick", 32'(tick[3]), 32'h0);
        step();
        chk("ch3_j3_tick", 32'(tick[3]), 32'h1);
        chk("ch2_new_tick2", 32'(tick[2]), 32'h0);

        // Stop ch3 with a write on its tick cycle: one more full period, then OFF
        cfg_write(2'd3, 3'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ch3_final_phase_k%0d", k), 32'(phase[3]), 32'(k >= 2));
            chk($sformatf("ch3_final_tick_k%0d", k), 32'(tick[3]), 32'(k == 3));
            chk($sformatf("ch3_final_pend_k%0d", k), 32'(pend[3]), 32'h1);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ch3_off_phase_k%0d", k), 32'(phase[3]), 32'h0);
            chk($sformatf("ch3_off_tick_k%0d", k), 32'(tick[3]), 32'h0);
            chk($sformatf("ch3_off_pend_k%0d", k), 32'(pend[3]), 32'h0);
            step();
        end

        // Reset while ch1 holds a staged config
        cfg_write(2'd1, 3'd3, 1'b1);
        chk("ch1_pend_before_rst", 32'(pend[1]), 32'h1);
        reset = 1'b1;
        #1;
        chk("async_rst_phase", 32'(phase), 32'h0);
        chk("async_rst_tick", 32'(tick), 32'h0);
        chk("async_rst_pend", 32'(pend), 32'h0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("post_rst_phase_k%0d", k), 32'(phase), 32'h0);
            chk($sformatf("post_rst_pend_k%0d", k), 32'(pend), 32'h0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
